uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
- Serial UART receiver; the downstream counterpart of the team's UART transmit controller.
- Samples the asynchronous uart_rx line at mid-bit and deserialises 8N1 frames (1 start, 8 data LSB-first, 1 stop, no parity).
- Presents each byte with a one-cycle valid strobe.
- Flags frames whose stop bit is low.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 9600, line rate in bits/s.
- BIT_CNT (local), CLK_FREQ/BAUD_RATE (integer divide), clk cycles per bit; 5208 at defaults.
- HALF_CNT (local), BIT_CNT/2, clk cycles from start-edge detection to start-bit mid-sample.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- uart_rx  in  1  serial line, idle high, asynchronous to clk.
- rx_data  out  8  last correctly received byte; held until the next good frame.
- rx_valid  out  1  one-clk pulse; rx_data is new this cycle.
- rx_frame_err  out  1  one-clk pulse; stop bit sampled low.
- rx_busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset: clk and rst_n are the clock and reset (rst_n asynchronous, active-low).
  - Both synchroniser flops reset to 1.
  - rx_data = 8'h00; rx_valid, rx_frame_err, rx_busy = 0.
  - State = IDLE; counters = 0.
  - Reset mid-frame aborts the frame immediately; no valid or err pulse is produced for it.
- Input path: 2-flop synchroniser on uart_rx. All decisions use the synchronised bit (rx_s). Adds 2 clk of latency.
- Bit-period counter: width $clog2(BIT_CNT). Cleared on every state entry. Increments each clk while not IDLE.
- FSM states:
  - IDLE: rx_s == 0 -> START.
  - START: at count == HALF_CNT-1, sample rx_s.
    - 0 -> DATA, with bit index = 0 and counter cleared.
    - 1 -> IDLE. This is glitch rejection: no err pulse.
  - DATA: at count == BIT_CNT-1, sample rx_s into shift[7]. Shift right so the data arrives LSB-first. Clear the counter.
    - If bit index == 7 -> STOP; otherwise increment bit index.
  - STOP: at count == BIT_CNT-1, sample rx_s.
    - 1 -> rx_data <= shift, rx_valid = 1 for one clk, -> IDLE.
    - 0 -> rx_frame_err = 1 for one clk, rx_data unchanged, -> BREAK.
  - BREAK: wait for rx_s == 1, then -> IDLE. This prevents a held-low line or break from being decoded as 0x00 frames.
- Sampling points: every data and stop sample lands at bit mid-point ±1 clk. Tolerates ±4% aggregate baud mismatch.
- Latency: rx_valid asserts HALF_CNT + 9*BIT_CNT clk after START entry, ±1. START entry is 3 clk after the physical falling edge.
- Back-to-back frames: return to IDLE occurs at mid-stop-bit. A start edge arriving immediately after the stop bit is caught with no frame lost.
- rx_valid and rx_frame_err are never high in the same cycle.
- uart_rx changes during a sample cycle need no special handling; the synchroniser output is authoritative.

Decomposition:
- Shared package uart_pkg holds:
  - State encoding enum: IDLE, START, DATA, STOP, BREAK.
  - Frame constants: DATA_BITS = 8, START_LVL = 0, STOP_LVL = 1, IDLE_LVL = 1.
  - Helper function for clk-per-bit computation, shared with the transmitter.
- One natural sub-module: rx_baud_tick. It is the bit-period counter with synchronous restart, a half/full compare, and a single-cycle sample_tick output. It is reusable by a future oversampled variant.
- The synchroniser, FSM, shift register and output registers stay in uart_rx_ctrl.

Test Plan: all scenarios run with CLK_FREQ=1600000 and BAUD_RATE=100000, giving BIT_CNT=16 and HALF_CNT=8.
- Single frame 0x55 after 40 clk idle -> exactly one rx_valid pulse, rx_data=8'h55, 152±1 clk after START entry; rx_frame_err stays 0; rx_busy high throughout the frame.
- Start glitch: uart_rx low for 4 clk then high -> rx_busy pulses high about 8 clk then returns to 0; no rx_valid or rx_frame_err; a following 0xC3 frame is received correctly.
- Framing error: 0xA3 sent with stop bit 0 and line held low 40 clk -> one rx_frame_err pulse, no rx_valid, rx_data keeps its previous value; after the line goes high, a 0x3C frame yields rx_valid with rx_data=8'h3C.
- Back-to-back frames 0x00 then 0xFF, single stop bit, no idle gap -> two rx_valid pulses 160±1 clk apart, carrying 8'h00 then 8'hFF.
- Reset mid-frame: rst_n low for 3 clk during data bit 3 of 0x96 -> all outputs 0 within the reset; no pulse for the aborted frame; line held idle then frame 0x69 -> rx_data=8'h69.
- Baud tolerance: frames 0x5A and 0xA5 driven at 103% and at 97% of BAUD_RATE -> both bytes received correctly with no rx_frame_err.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, 8N1 frame constants and baud helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned IDX_W     = $clog2(DATA_BITS);
  localparam logic        START_LVL = 1'b0;
  localparam logic        STOP_LVL  = 1'b1;
  localparam logic        IDLE_LVL  = 1'b1;

  function automatic int unsigned clk_per_bit(int unsigned clk_freq, int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/rx_baud_tick.sv
// Bit-period counter: counts while running, fires a one-cycle tick at the half or full
// bit compare, and clears itself on the tick or on restart.
module rx_baud_tick #(
  parameter int unsigned BIT_CNT  = 16,
  parameter int unsigned HALF_CNT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic run,
  input  logic half_sel,
  output logic sample_tick
);

  localparam int unsigned CW = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;

  logic [CW-1:0] count;
  logic [CW-1:0] target;

  assign target      = half_sel ? CW'(HALF_CNT - 1) : CW'(BIT_CNT - 1);
  assign sample_tick = run && (count == target);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (restart || sample_tick) begin
      count <= '0;
    end else if (run) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// 8N1 UART receiver: synchronises the line, samples mid-bit, emits a byte with a one-cycle
// valid strobe and flags frames whose stop bit is low.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int unsigned BIT_CNT  = clk_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int unsigned HALF_CNT = BIT_CNT / 2;

  logic [1:0]           sync;
  logic                 rx_s;
  rx_state_e            state;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 tick;
  logic                 run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= {IDLE_LVL, IDLE_LVL};
    end else begin
      sync <= {sync[0], uart_rx};
    end
  end

  assign rx_s    = sync[1];
  assign run     = (state == START) || (state == DATA) || (state == STOP);
  assign rx_busy = (state != IDLE);

  // Counter is held at zero outside the timed states, so every state entry starts from 0.
  rx_baud_tick #(
    .BIT_CNT (BIT_CNT),
    .HALF_CNT(HALF_CNT)
  ) u_baud (
    .clk        (clk),
    .rst_n      (rst_n),
    .restart    (!run),
    .run        (run),
    .half_sel   (state == START),
    .sample_tick(tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bit_idx      <= '0;
      shift        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rx_s == START_LVL) state <= START;
        end
        START: begin
          if (tick) begin
            if (rx_s == START_LVL) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        DATA: begin
          if (tick) begin
            shift <= {rx_s, shift[DATA_BITS-1:1]};
            if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (rx_s == STOP_LVL) begin
              rx_data  <= shift;
              rx_valid <= 1'b1;
              state    <= IDLE;
            end else begin
              rx_frame_err <= 1'b1;
              state        <= BREAK;
            end
          end
        end
        BREAK: begin
          // Held-low line must return high before a new start edge is accepted.
          if (rx_s == IDLE_LVL) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl at 16 clk per bit: stimulus queues expected pulses,
// a negedge monitor pops and checks them as the receiver emits them.
`timescale 1ns / 1ps
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
    int         exp_cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   vcyc[$];

  uart_rx_ctrl #(
    .CLK_FREQ (1600000),
    .BAUD_RATE(100000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .uart_rx     (uart_rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err),
    .rx_busy     (rx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // kind: 0 = no pulse expected, 1 = rx_valid with data, 2 = rx_frame_err.
  // Edge-to-pulse latency at nominal rate: 3 sync/detect + 8 half-bit + 9*16 = 155 clk.
  task automatic send(input logic [7:0] d, input logic stop, input int bit_ns, input int kind);
    logic [9:0] f;
    exp_t       x;
    f = {stop, d, 1'b0};
    if (kind != 0) begin
      x.is_err  = (kind == 2);
      x.data    = d;
      x.exp_cyc = (bit_ns == 160) ? cyc + 155 : -1;
      q.push_back(x);
    end
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      #(bit_ns);
    end
  endtask

  always @(negedge clk) begin
    if (rx_valid || rx_frame_err) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: valid=%0b err=%0b data=%0h none expected (cyc %0d)",
                 rx_valid, rx_frame_err, rx_data, cyc);
      end else begin
        e = q.pop_front();
        check("pulse_kind", {30'd0, rx_valid, rx_frame_err}, {30'd0, !e.is_err, e.is_err});
        if (!e.is_err) begin
          check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
          vcyc.push_back(cyc);
        end
        if (e.exp_cyc >= 0) begin
          total++;
          if (cyc < e.exp_cyc - 1 || cyc > e.exp_cyc + 1) begin
            bad++;
            $display("FAIL latency: pulse at cyc %0d expected %0d +-1", cyc, e.exp_cyc);
          end
        end
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {21'd0, rx_data, rx_valid, rx_frame_err, rx_busy}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_clk(40);
    check("idle_busy", {31'd0, rx_busy}, 32'd0);

    // Single frame with busy observed mid-frame.
    fork
      send(8'h55, 1'b1, 160, 1);
      begin
        wait_clk(20);
        check("busy_early", {31'd0, rx_busy}, 32'd1);
        wait_clk(120);
        check("busy_late", {31'd0, rx_busy}, 32'd1);
      end
    join
    wait_clk(20);
    check("busy_after", {31'd0, rx_busy}, 32'd0);

    // Start glitch: 4 clk low, rejected at the half-bit sample.
    uart_rx = 1'b0;
    wait_clk(4);
    uart_rx = 1'b1;
    check("glitch_busy", {31'd0, rx_busy}, 32'd1);
    wait_clk(10);
    check("glitch_idle", {31'd0, rx_busy}, 32'd0);
    wait_clk(20);
    send(8'hC3, 1'b1, 160, 1);
    wait_clk(20);

    // Framing error followed by a held-low line.
    send(8'hA3, 1'b0, 160, 2);
    wait_clk(40);
    check("ferr_data_held", {24'd0, rx_data}, 32'h0000_00C3);
    check("break_busy", {31'd0, rx_busy}, 32'd1);
    uart_rx = 1'b1;
    wait_clk(20);
    check("break_exit", {31'd0, rx_busy}, 32'd0);
    send(8'h3C, 1'b1, 160, 1);
    wait_clk(20);

    // Back-to-back frames, no idle gap.
    send(8'h00, 1'b1, 160, 1);
    send(8'hFF, 1'b1, 160, 1);
    wait_clk(20);
    if (vcyc.size() >= 2) begin
      total++;
      if (vcyc[$] - vcyc[$-1] < 159 || vcyc[$] - vcyc[$-1] > 161) begin
        bad++;
        $display("FAIL b2b_gap: got %0d clk expected 160 +-1", vcyc[$] - vcyc[$-1]);
      end
    end else begin
      total++;
      bad++;
      $display("FAIL b2b_gap: got %0d valid pulses expected at least 2", vcyc.size());
    end

    // Reset during data bit 3 of 0x96 (start + bits 0..2 sent, then half of bit 3).
    begin
      logic [9:0] f;
      f = {1'b1, 8'h96, 1'b0};
      for (int i = 0; i < 4; i++) begin
        uart_rx = f[i];
        #160;
      end
      uart_rx = f[4];
      #80;
    end
    check("pre_reset_busy", {31'd0, rx_busy}, 32'd1);
    rst_n   = 1'b0;
    uart_rx = 1'b1;
    @(negedge clk);
    check("mid_reset_outputs", {21'd0, rx_data, rx_valid, rx_frame_err, rx_busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_clk(40);
    send(8'h69, 1'b1, 160, 1);
    wait_clk(20);

    // Baud tolerance: ~103% (155 ns/bit) and ~97% (165 ns/bit) of nominal 160 ns/bit.
    send(8'h5A, 1'b1, 155, 1);
    wait_clk(20);
    send(8'hA5, 1'b1, 155, 1);
    wait_clk(20);
    send(8'h5A, 1'b1, 165, 1);
    wait_clk(20);
    send(8'hA5, 1'b1, 165, 1);

    for (int i = 0; i < 400 && q.size() != 0; i++) wait_clk(1);
    wait_clk(20);
    check("queue_drained", q.size(), 32'd0);
    check("final_data", {24'd0, rx_data}, 32'h0000_00A5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
